// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port; define WBARB_CONFLICT_CNT_EN to add conflict_cnt
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wb_stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [ADDR_WIDTH-1:0]          addr_w,
    output logic [DATA_WIDTH-1:0]          data_w,
    output logic                           write_en,
`ifdef WBARB_CONFLICT_CNT_EN
    output logic [31:0]                    conflict_cnt,
`endif
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);
    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         gnt;
    logic                  any;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin search from rr_ptr upward with wrap; the lowest offset wins
    always_comb begin
        logic [GW:0] idx;
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ))
                idx = idx - (GW+1)'(NUM_REQ);
            if (req_valid[idx[GW-1:0]]) begin
                gnt = idx[GW-1:0];
                any = 1'b1;
            end
        end
    end

    assign req_ready = (any && !wb_stall && rst_n) ? (NUM_REQ'(1) << gnt) : '0;
    assign hs        = |req_ready;
    assign sel_addr  = req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data  = req_data[gnt*DATA_WIDTH +: DATA_WIDTH];

    // Output stage: capture the granted write; R0 is accepted but never enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en <= 1'b0;
            addr_w   <= '0;
            data_w   <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            write_en <= hs && (|sel_addr);
            if (hs) begin
                addr_w   <= sel_addr;
                data_w   <= sel_data;
                grant_id <= gnt;
                rr_ptr   <= (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

`ifdef WBARB_CONFLICT_CNT_EN
    // Saturating count of unstalled cycles with two or more competing requesters
    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (!wb_stall && $countones(req_valid) >= 2 && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_stall = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [AW-1:0]   addr_w;
    logic [DW-1:0]   data_w;
    logic            write_en;
    logic [1:0]      grant_id;
`ifdef WBARB_CONFLICT_CNT_EN
    logic [31:0]     conflict_cnt;
`endif

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .addr_w(addr_w), .data_w(data_w), .write_en(write_en),
`ifdef WBARB_CONFLICT_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          m_ptr = 0;
    logic        m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int          m_gid = 0;
    logic [31:0] m_cnt = '0;
    logic [N-1:0] m_acc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        int g;
        logic [N-1:0] er;
        g = pick();
        er = (g >= 0 && !wb_stall && rst_n) ? N'(1 << g) : '0;
        @(negedge clk);
        check("ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        m_acc = '0;
        if (!rst_n) begin
            m_we = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 0; m_cnt = '0;
        end else begin
            if (!wb_stall && $countones(req_valid) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (er != '0) begin
                m_acc  = er;
                m_addr = req_addr[g*AW +: AW];
                m_data = req_data[g*DW +: DW];
                m_gid  = g;
                m_ptr  = (g + 1) % N;
                m_we   = (m_addr != 0);
            end else m_we = 0;
        end
        #1;
        check("write_en", 64'(write_en), 64'(m_we));
        check("addr_w", 64'(addr_w), 64'(m_addr));
        check("data_w", 64'(data_w), 64'(m_data));
        check("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef WBARB_CONFLICT_CNT_EN
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
    endtask

    initial begin
        // reset held with all requesters valid
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(i + 10));
        tick(); tick();
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_we", 64'(write_en), 64'(0));
        // single request from requester 1
        rst_n = 1'b1;
        req_valid = '0;
        set_req(1, 1'b1, 5'd1, 32'hDEADBEEF);
        tick();
        check("single_data", 64'(data_w), 64'h0000_0000_DEAD_BEEF);
        check("single_gid", 64'(grant_id), 64'(1));
        req_valid = '0;
        tick();
        check("single_we_drop", 64'(write_en), 64'(0));
        // round-robin from a fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd2, 32'hB);
        set_req(2, 1'b1, 5'd3, 32'hC);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_gid", 64'(grant_id), 64'(i % 3));
            check("rr_data", 64'(data_w), 64'(32'hA + (i % 3)));
        end
        // R0 request is consumed without a write and advances the pointer
        req_valid = '0;
        set_req(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_req(1, 1'b1, 5'd7, 32'h1234);
        tick();
        check("r0_we", 64'(write_en), 64'(0));
        check("r0_gid", 64'(grant_id), 64'(0));
        req_valid[0] = 1'b0;
        tick();
        check("r0_next_gid", 64'(grant_id), 64'(1));
        // stall holds a pending request
        req_valid = '0;
        wb_stall = 1'b1;
        set_req(2, 1'b1, 5'd2, 32'hCAFEBABE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we", 64'(write_en), 64'(0));
        end
        wb_stall = 1'b0;
        tick();
        check("stall_addr", 64'(addr_w), 64'(2));
        check("stall_we_after", 64'(write_en), 64'(1));
        // reset in the middle of contention
        req_valid = '0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_req(0, 1'b1, 5'd4, 32'h40);
        set_req(2, 1'b1, 5'd6, 32'h60);
        for (int i = 0; i < 4; i++) tick();
`ifdef WBARB_CONFLICT_CNT_EN
        check("cnt_4", 64'(conflict_cnt), 64'(4));
`endif
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_we", 64'(write_en), 64'(0));
        tick();
        check("midrst_gid", 64'(grant_id), 64'(0));
        // randomized traffic honouring the hold-until-ready rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || m_acc[i])
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            wb_stall = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 39) != 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
